ps2_teclado_ascii: RTL

Upstream input stage for the free-play note FSM. It receives PS/2 keyboard frames (scan-code set 2) and decodes make/break sequences for keys a–d. It presents the held key as an 8-bit ASCII level on `tecla`, which drives the FSM's `entrada` directly. `tecla` reads 0 whenever none of the mapped keys is held.

---
 rtl/ps2_teclado_ascii.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ps2_teclado_ascii.sv
`timescale 1ns/1ps
// PS/2 keyboard front end: conditions the bus, receives set-2 frames and
// turns make/break codes for keys a-d into a held-key ASCII level.
module ps2_teclado_ascii #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] tecla,
    output logic       nueva_tecla,
    output logic       error_trama
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {REPOSO, DATOS, PARIDAD, PARADA} estado_t;

    logic          clk_s1_reg, clk_s2_reg, data_s1_reg, data_s2_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_reg, filt_d_reg, caida_reg;

    estado_t       estado_reg;
    logic [3:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          par_reg;
    logic [TW-1:0] tout_reg;
    logic          byte_ok_reg;
    logic [7:0]    byte_rx_reg;

    logic          rotura_reg, extendido_reg;

    function automatic logic [7:0] mapa(input logic [7:0] code);
        case (code)
            8'h1C:   mapa = 8'd97;
            8'h32:   mapa = 8'd98;
            8'h21:   mapa = 8'd99;
            8'h23:   mapa = 8'd100;
            default: mapa = 8'd0;
        endcase
    endfunction

    // Synchronizers and glitch filter idle high, like the bus itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_reg   <= 1'b1;
            clk_s2_reg   <= 1'b1;
            data_s1_reg  <= 1'b1;
            data_s2_reg  <= 1'b1;
            filt_cnt_reg <= '0;
            filt_reg     <= 1'b1;
            filt_d_reg   <= 1'b1;
            caida_reg    <= 1'b0;
        end else begin
            clk_s1_reg  <= ps2_clk;
            clk_s2_reg  <= clk_s1_reg;
            data_s1_reg <= ps2_data;
            data_s2_reg <= data_s1_reg;
            if (clk_s2_reg == filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                filt_reg     <= clk_s2_reg;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
            filt_d_reg <= filt_reg;
            caida_reg  <= filt_d_reg & ~filt_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_reg  <= REPOSO;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_reg     <= 1'b0;
            tout_reg    <= '0;
            byte_ok_reg <= 1'b0;
            byte_rx_reg <= '0;
            error_trama <= 1'b0;
        end else begin
            byte_ok_reg <= 1'b0;
            error_trama <= 1'b0;
            if (caida_reg) begin
                tout_reg <= '0;
                case (estado_reg)
                    REPOSO: begin
                        if (!data_s2_reg) begin
                            estado_reg  <= DATOS;
                            bit_cnt_reg <= '0;
                        end
                    end
                    DATOS: begin
                        shift_reg   <= {data_s2_reg, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7)
                            estado_reg <= PARIDAD;
                    end
                    PARIDAD: begin
                        par_reg    <= data_s2_reg;
                        estado_reg <= PARADA;
                    end
                    PARADA: begin
                        if ((^{shift_reg, par_reg}) && data_s2_reg) begin
                            byte_ok_reg <= 1'b1;
                            byte_rx_reg <= shift_reg;
                        end else begin
                            error_trama <= 1'b1;
                        end
                        estado_reg <= REPOSO;
                    end
                    default: estado_reg <= REPOSO;
                endcase
            end else if (estado_reg != REPOSO) begin
                if (tout_reg == TW'(TIMEOUT_CYC)) begin
                    error_trama <= 1'b1;
                    estado_reg  <= REPOSO;
                    tout_reg    <= '0;
                end else begin
                    tout_reg <= tout_reg + 1'b1;
                end
            end
        end
    end

    // Break/extended prefixes are one-shot flags consumed by the next code byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tecla         <= '0;
            nueva_tecla   <= 1'b0;
            rotura_reg    <= 1'b0;
            extendido_reg <= 1'b0;
        end else begin
            nueva_tecla <= 1'b0;
            if (error_trama) begin
                rotura_reg    <= 1'b0;
                extendido_reg <= 1'b0;
            end else if (byte_ok_reg) begin
                if (byte_rx_reg == 8'hF0) begin
                    rotura_reg <= 1'b1;
                end else if (byte_rx_reg == 8'hE0) begin
                    extendido_reg <= 1'b1;
                end else if (extendido_reg) begin
                    rotura_reg    <= 1'b0;
                    extendido_reg <= 1'b0;
                end else if (rotura_reg) begin
                    if (mapa(byte_rx_reg) == tecla)
                        tecla <= '0;
                    rotura_reg <= 1'b0;
                end else if (mapa(byte_rx_reg) != 8'd0 && mapa(byte_rx_reg) != tecla) begin
                    tecla       <= mapa(byte_rx_reg);
                    nueva_tecla <= 1'b1;
                end
            end
        end
    end

endmodule
